seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider that complements the combinational 4-bit add/increment/subtract/decrement unit. Multiplication is not provided; this block supplies the inverse of repeated addition: the quotient and remainder of two unsigned operands. It resolves one quotient bit per clock by trial subtraction. It sits beside the arithmetic unit in the non-memory datapath and uses a start/busy/done handshake so that a controller can issue one division and wait for the result.

---
 rtl/arith_pkg.sv | 13 +
 rtl/div_step.sv | 30 +++
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the non-memory datapath: default operand
// width and the sequential divider state encoding.
package arith_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // subtraction needs one extra bit; its MSB is the borrow.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// resolves one quotient bit per clock.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] q_r;
  // After every restoring step the partial remainder is below the divisor,
  // so its top bit is always zero and only WIDTH bits are kept.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rem_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_r),
    .q       (q_r),
    .divisor (divisor_r),
    .rem_next(rem_next),
    .q_next  (q_next)
  );

  // Working registers carry no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              divisor_r   <= divisor;
              q_r         <= dividend;
              rem_r       <= '0;
              cnt         <= CNT_W'(WIDTH);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            quotient  <= q_next;
            remainder <= rem_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, divide-by-zero, ignored
// starts, mid-calculation reset and a full sweep of 4-bit operand pairs.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int nassert = 0;
  int nfail   = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division from IDLE, follow it to its done pulse and check
  // latency, busy duration, results and pulse width. Returns one cycle after
  // done, so a following call starts at the earliest legal edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int           lat;
    int           bcnt;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    if (b == 0) begin
      eq = '1; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check({tag, " latency"},     lat,         (b == 0) ? 0 : W);
    check({tag, " busy_cycles"}, bcnt,        (b == 0) ? 0 : W);
    check({tag, " busy_at_done"}, busy,       0);
    check({tag, " quotient"},    quotient,    eq);
    check({tag, " remainder"},   remainder,   er);
    check({tag, " div_by_zero"}, div_by_zero, edz);
    tick();
    check({tag, " done_width"},  done,        0);
  endtask

  initial begin
    int dcnt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("reset busy",        busy,        0);
    check("reset done",        done,        0);
    check("reset quotient",    quotient,    0);
    check("reset remainder",   remainder,   0);
    check("reset div_by_zero", div_by_zero, 0);

    // rst wins over start on the same edge
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    tick();
    check("rst_over_start busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_over_start idle", busy, 0);

    run_div(4'd13, 4'd3, "13/3");
    run_div(4'd15, 4'd1, "15/1");
    run_div(4'd5,  4'd7, "5/7");
    run_div(4'd0,  4'd9, "0/9");
    run_div(4'd9,  4'd0, "9/0");
    run_div(4'd8,  4'd2, "8/2");

    // start re-pulsed during CALC must be ignored
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    dividend = 4'd14;
    divisor  = 4'd2;
    tick();
    start = 1'b0;
    dcnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dcnt++;
        check("ignore quotient",  quotient,  4);
        check("ignore remainder", remainder, 1);
      end
      tick();
    end
    check("ignore done_pulses", dcnt, 1);

    // reset during the second CALC cycle discards the division
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy",        busy,        0);
    check("midrst done",        done,        0);
    check("midrst quotient",    quotient,    0);
    check("midrst remainder",   remainder,   0);
    check("midrst div_by_zero", div_by_zero, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dcnt++;
      tick();
    end
    check("midrst no_activity", dcnt, 0);
    run_div(4'd7, 4'd2, "7/2");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), $sformatf("sweep %0d/%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
